score_counter: RTL and testbench

SCORE_COUNTER -- requirements
Module: score_counter

---
 rtl/score_counter.sv | 104 ++++++++++
 tb/tb_score_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/score_counter.sv
// Two-player BCD score counter with goal edge detection and a PLAY/OVER FSM.
// Define SCORE_WIN_LIMIT_EN to stop the game when a score reaches WIN_SCORE; otherwise scores wrap 99 -> 00.
module score_counter #(
  parameter int unsigned WIN_SCORE = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       goal1,
  input  logic       goal2,
  input  logic       clear,
  output logic [3:0] score1units,
  output logic [3:0] score1tens,
  output logic [3:0] score2units,
  output logic [3:0] score2tens,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic {PLAY, OVER} state_t;

  state_t     state;
  logic       goal1_q;
  logic       goal2_q;
  logic       rise1;
  logic       rise2;
  logic [7:0] next1;
  logic [7:0] next2;

  // Packed {tens, units} BCD increment; units 9 carries into tens, 99 wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] units);
    logic [3:0] t;
    logic [3:0] u;
    if (units == 4'd9) begin
      u = 4'd0;
      t = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
    end else begin
      u = units + 4'd1;
      t = tens;
    end
    return {t, u};
  endfunction

  always_comb begin
    rise1 = goal1 & ~goal1_q;
    rise2 = goal2 & ~goal2_q;
    next1 = bcd_inc(score1tens, score1units);
    next2 = bcd_inc(score2tens, score2units);
  end

`ifdef SCORE_WIN_LIMIT_EN
  localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};
  logic hit1;
  logic hit2;
  // A player wins on the edge that takes his score to WIN_SCORE.
  assign hit1 = rise1 && (next1 == WIN_BCD);
  assign hit2 = rise2 && (next2 == WIN_BCD);
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PLAY;
      goal1_q     <= 1'b0;
      goal2_q     <= 1'b0;
      score1units <= 4'd0;
      score1tens  <= 4'd0;
      score2units <= 4'd0;
      score2tens  <= 4'd0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
    end else begin
      // History tracks the inputs even on clear, so a held goal is not re-counted afterwards.
      goal1_q <= goal1;
      goal2_q <= goal2;
      if (clear) begin
        state       <= PLAY;
        score1units <= 4'd0;
        score1tens  <= 4'd0;
        score2units <= 4'd0;
        score2tens  <= 4'd0;
        game_over   <= 1'b0;
        winner      <= 2'b00;
      end else begin
        case (state)
          PLAY: begin
            if (rise1) {score1tens, score1units} <= next1;
            if (rise2) {score2tens, score2units} <= next2;
`ifdef SCORE_WIN_LIMIT_EN
            if (hit1 || hit2) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= {hit2, hit1};
            end
`endif
          end
          default: begin
            // OVER: scores and winner are frozen until clear or reset.
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_counter.sv
// Scoreboard bench for score_counter: an integer model predicts each cycle's outputs, compared after the edge.
// Runs in either build; expectations follow SCORE_WIN_LIMIT_EN when it is defined.
module tb_score_counter;

  localparam int WIN = 11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       goal1 = 1'b0;
  logic       goal2 = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] score1units, score1tens, score2units, score2tens;
  logic       game_over;
  logic [1:0] winner;

  typedef struct packed {
    logic [3:0] t1;
    logic [3:0] u1;
    logic [3:0] t2;
    logic [3:0] u2;
    logic       over;
    logic [1:0] win;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   check_count = 0;
  int   pass_count  = 0;

  // Reference model state (binary scores, not BCD).
  int         m_s1, m_s2;
  bit         m_p1, m_p2, m_over;
  logic [1:0] m_win;

  score_counter #(.WIN_SCORE(WIN)) dut (
    .clk(clk), .reset(reset), .goal1(goal1), .goal2(goal2), .clear(clear),
    .score1units(score1units), .score1tens(score1tens),
    .score2units(score2units), .score2tens(score2tens),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic obs_t dut_out();
    return '{score1tens, score1units, score2tens, score2units, game_over, winner};
  endfunction

  function automatic obs_t model_out();
    return '{4'(m_s1 / 10), 4'(m_s1 % 10), 4'(m_s2 / 10), 4'(m_s2 % 10), m_over, m_win};
  endfunction

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_p1 = 0; m_p2 = 0; m_over = 0; m_win = 2'b00;
  endfunction

  function automatic void model_step(input bit g1, input bit g2, input bit clr);
    bit r1, r2;
    r1 = g1 && !m_p1;
    r2 = g2 && !m_p2;
    m_p1 = g1;
    m_p2 = g2;
    if (clr) begin
      m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 2'b00;
    end else if (!m_over) begin
      if (r1) m_s1 = (m_s1 + 1) % 100;
      if (r2) m_s2 = (m_s2 + 1) % 100;
`ifdef SCORE_WIN_LIMIT_EN
      if ((r1 && m_s1 == WIN) || (r2 && m_s2 == WIN)) begin
        m_over = 1;
        m_win  = {r2 && m_s2 == WIN, r1 && m_s1 == WIN};
      end
`endif
    end
  endfunction

  // Drive one cycle of inputs, push the prediction, then capture the DUT after the edge.
  task automatic cycle(input bit g1, input bit g2, input bit clr);
    @(negedge clk);
    goal1 = g1; goal2 = g2; clear = clr;
    model_step(g1, g2, clr);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    obs_q.push_back(dut_out());
  endtask

  task automatic pulse(input bit g1, input bit g2);
    cycle(g1, g2, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    obs_t o;
    model_reset();
    reset = 1'b1;
    #12;
    o = dut_out();
    check_count++;
    if (o !== model_out()) $display("FAIL reset: got %h required %h", o, model_out());
    else pass_count++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_twelve_pulses();
    obs_t e, o;
    for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      check_count++;
      if (o !== e) $display("FAIL twelve_pulses: got %h required %h", o, e);
      else pass_count++;
    end
  endtask

  task automatic test_held_high();
    obs_t e, o;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      check_count++;
      if (o !== e) $display("FAIL held_high: got %h required %h", o, e);
      else pass_count++;
    end
  endtask

  task automatic test_tie_at_win();
    obs_t e, o;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      check_count++;
      if (o !== e) $display("FAIL tie_at_win: got %h required %h", o, e);
      else pass_count++;
    end
  endtask

  task automatic test_wrap_and_clear();
    obs_t e, o;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 99; i++) pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    // Clear with a coincident goal1 edge: the goal is discarded.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    // goal1 held across a clear does not count afterwards.
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      check_count++;
      if (o !== e) $display("FAIL wrap_and_clear: got %h required %h", o, e);
      else pass_count++;
    end
  endtask

  task automatic test_async_reset();
    obs_t e, o;
    cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 47; i++) pulse(1'b1, 1'b0);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    o = dut_out();
    check_count++;
    if (o !== model_out()) $display("FAIL async_reset: got %h required %h", o, model_out());
    else pass_count++;
    #2;
    reset = 1'b0;
    goal2 = 1'b1;
    goal1 = 1'b0;
    clear = 1'b0;
    model_step(1'b0, 1'b1, 1'b0);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    obs_q.push_back(dut_out());
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      check_count++;
      if (o !== e) $display("FAIL async_reset_seq: got %h required %h", o, e);
      else pass_count++;
    end
  endtask

  initial begin
    test_reset();
    test_twelve_pulses();
    test_held_high();
    test_tie_at_win();
    test_wrap_and_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
